// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N flattened input streams plus one output stream.
// The mux uses the slave view; a source/sink model drives through the master view.
interface stream_mux_rr_if #(
  parameter int N_INPUTS   = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]            in_valid;
  logic [N_INPUTS-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [SEL_W-1:0]               out_src;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// mode 0 routes the channel named by sel; mode 1 arbitrates round-robin over valid channels.
module stream_mux_rr #(
  parameter  int N_INPUTS   = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_W      = $clog2(N_INPUTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_rr_if.slave   bus
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_src_q, out_src_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic                  load_s;
  logic                  grant_vld_s;
  logic [SEL_W-1:0]      grant_idx_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic [N_INPUTS-1:0]   in_ready_s;
  logic                  xfer_s;

  // Nothing is accepted while reset is held, even though the output stage reads as empty.
  assign load_s = rst_n & (~out_valid_q | bus.out_ready);

  // Grant selection: fixed index in mode 0, first valid channel after rr_ptr in mode 1.
  always_comb begin
    int                cand;
    logic [SEL_W-1:0]  cand_idx;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand        = 0;
    cand_idx    = '0;
    if (mode == 1'b0) begin
      if (int'(sel) < N_INPUTS) begin
        grant_vld_s = 1'b1;
        grant_idx_s = sel;
      end else begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
      end
    end else begin
      // Walk from the farthest candidate to the nearest so the nearest valid one wins.
      for (int k = N_INPUTS; k >= 1; k--) begin
        cand        = int'(rr_ptr_q) + k;
        cand        = (cand >= N_INPUTS) ? (cand - N_INPUTS) : cand;
        cand_idx    = SEL_W'(cand);
        grant_vld_s = grant_vld_s | bus.in_valid[cand_idx];
        grant_idx_s = bus.in_valid[cand_idx] ? cand_idx : grant_idx_s;
      end
    end
  end

  // Payload of the granted channel and the one-hot ready vector.
  always_comb begin
    grant_data_s = '0;
    in_ready_s   = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        grant_data_s  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready_s[i] = load_s & grant_vld_s;
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  assign xfer_s = |(in_ready_s & bus.in_valid);

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_s) begin
      out_valid_d = xfer_s;
      if (xfer_s) begin
        out_data_d = grant_data_s;
        out_src_d  = grant_idx_s;
        rr_ptr_d   = grant_idx_s;
      end else begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; rr_ptr resets to the last channel so channel 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_INPUTS - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N:1 streaming multiplexer with a valid/ready handshake on every input and on the output, and a registered output stage. Two modes:
- Fixed: software-style selection through `sel`.
- Round-robin: fair arbitration across all requesting channels.

It feeds the operand and result routing paths of the TPU datapath wherever producers and consumers can stall.

Parameters:
- N_INPUTS, 16, number of input channels (2..64); SEL_W = $clog2(N_INPUTS) is derived, not overridable.
- DATA_WIDTH, 32, payload width per channel in bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode = 0
- in_data  input  N_INPUTS*DATA_WIDTH  flattened payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  N_INPUTS  per-channel valid
- in_ready  output  N_INPUTS  per-channel ready (combinational)
- out_data  output  DATA_WIDTH  registered payload
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready
- out_src  output  SEL_W  index of the channel that produced the current out_data

Behaviour:
- Reset (async assert, sync release by the system): out_valid = 0, out_data = 0, out_src = 0, rr_ptr = N_INPUTS-1. With this pointer value, channel 0 has first priority after reset.
- Load enable: load = !out_valid || out_ready. The output register accepts new data only when load = 1.
- Grant, combinational, one-hot or none:
  - mode 0: grant = sel if sel < N_INPUTS, otherwise no grant.
  - mode 1: grant = first i with in_valid[i] = 1, searching cyclically from rr_ptr+1 and wrapping at N_INPUTS-1 → 0. No grant if no valid.
- in_ready[i] = load && grant == i. All other ready bits are 0, and at most one in_ready bit is high per cycle.
- Mode 0: in_ready[sel] may be high while in_valid[sel] = 0; no transfer occurs.
- Transfer on channel i: in_valid[i] && in_ready[i]. At the next edge: out_data ← channel i payload, out_src ← i, out_valid ← 1.
- rr_ptr ← i on any transfer, in either mode, so round-robin continues fairly after a mode switch.
- If load = 1 and no transfer occurs, out_valid ← 0 at the next edge and out_data/out_src hold.
- If load = 0, out_data, out_src and out_valid hold: full backpressure, no data loss, no duplication.
- Latency: 1 cycle input→output. Throughput: one beat per cycle when out_ready is held high.
- Simultaneous consume and refill: out_valid && out_ready and a new transfer in the same cycle → the new beat replaces the old, and out_valid stays 1.
- mode and sel are sampled combinationally each cycle. A change takes effect in the same cycle's grant. The registered output is never altered by a mode or sel change.
- Fairness: in mode 1 with all channels continuously valid and out_ready = 1, grants cycle 0,1,…,N-1,0,… Each channel waits at most N_INPUTS-1 transfers.
- Protocol rules for sources:
  - in_valid must not depend on in_ready.
  - Once asserted, in_valid and in_data must hold until transfer.
  - The block does not check these rules.
- Reset mid-operation: the output beat is dropped (out_valid → 0 immediately, asynchronously) and rr_ptr returns to N_INPUTS-1.
- No internal combinational path from out_ready to out_data/out_valid. The only combinational path from out_ready is out_ready → in_ready.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → out_valid = 0, out_data = 0, out_src = 0, in_ready = 0. Release, mode = 1, all valid → first output beat has out_src = 0.
- Fixed pass-through: mode = 0, sel = 5, in_valid[5] = 1, data 0xDEADBEEF, out_ready = 1 → out_data = 0xDEADBEEF, out_src = 5 one cycle later. in_ready is high only on bit 5.
- Backpressure: mode = 0, stream 0x1, 0x2, 0x3 on channel 2, out_ready low for 3 cycles after the first beat → out_data holds 0x1 while stalled. Sequence delivered exactly 1, 2, 3 with no loss or duplication.
- Round-robin fairness: N = 16, all valid, out_ready = 1, 40 cycles → out_src sequence 0..15, 0..15, 0..7.
- Round-robin skip: only channels 3 and 11 valid → out_src alternates 3, 11, 3, 11. Dropping channel 3's valid → 11 every cycle. Out-of-range select: mode = 0, N = 12, sel = 13 → in_ready = 0 and out_valid falls to 0.
- Async reset mid-stream: assert rst_n low between edges while out_valid = 1 → out_valid drops immediately. After release, mode 1 grant restarts from channel 0.
